// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package instr_fetch_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic {
    S_RUN   = 1'b0,
    S_DRAIN = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [31:0]        pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of {pc, instr} entries; storage is register based so the
// head is presented straight from a flop.
module fetch_fifo import instr_fetch_pkg::*; #(
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned PW    = $clog2(DEPTH),
  localparam int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic         i_flush,
  input  fetch_entry_t i_data,
  output fetch_entry_t o_head,
  output logic         o_full,
  output logic         o_empty,
  output logic [CW-1:0] o_count
);

  fetch_entry_t  r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_pop;

  assign w_pop = i_pop && (r_count != '0);

  // Flush wins over push/pop; pointers wrap naturally since DEPTH is 2^PW.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (i_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!i_push && w_pop) r_count <= r_count - 1'b1;
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

  a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n)
    (i_push && !i_flush) |-> !o_full);

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the fetch PC, issues one outstanding imem request at a
// time, buffers returned words and handles redirects (with a drain state).
module instr_fetch import instr_fetch_pkg::*; #(
  parameter  logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter  int unsigned FIFO_DEPTH = 2,
  localparam int unsigned CW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               redirect_i,
  input  logic [31:0]        redirect_pc_i,
  output logic               imem_req_o,
  output logic [31:0]        imem_addr_o,
  input  logic               imem_ack_i,
  input  logic [INSTR_W-1:0] imem_rdata_i,
  output logic               instr_valid_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic [31:0]        instr_pc_o,
  input  logic               instr_ready_i,
  output fetch_state_t       dbg_state_o,
  output logic [CW-1:0]      dbg_count_o
);

  // Handshakes: imem transfers when req && ack in the same cycle, and req/addr
  // stay frozen while req is high without ack. Downstream transfers when
  // instr_valid_o && instr_ready_i; valid never depends on ready.

  fetch_state_t r_state;
  logic [31:0]  r_fpc;
  logic [31:0]  r_tgt;
  logic         r_pend;
  logic         r_started;

  logic          w_req;
  logic          w_ack;
  logic          w_push;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  logic [CW-1:0] w_count;
  logic [31:0]   w_redir_pc;
  fetch_entry_t  w_wdata;
  fetch_entry_t  w_head;

  assign w_redir_pc = align_pc(redirect_pc_i);

  // r_pend keeps an un-acked request alive across redirects (no abort).
  assign w_req  = r_started && (r_pend || ((r_state == S_RUN) && !w_full && !redirect_i));
  assign w_ack  = w_req && imem_ack_i;
  assign w_push = w_ack && (r_state == S_RUN) && !redirect_i;
  assign w_pop  = instr_valid_o && instr_ready_i && !redirect_i;
  assign w_wdata = {r_fpc, imem_rdata_i};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_RUN;
      r_fpc     <= RESET_PC;
      r_tgt     <= '0;
      r_pend    <= 1'b0;
      r_started <= 1'b0;
    end else begin
      r_started <= 1'b1;
      r_pend    <= w_req && !imem_ack_i;
      case (r_state)
        S_RUN: begin
          if (redirect_i) begin
            if (w_req && !imem_ack_i) begin
              r_state <= S_DRAIN;
              r_tgt   <= w_redir_pc;
            end else begin
              r_fpc <= w_redir_pc;
            end
          end else if (w_ack) begin
            r_fpc <= r_fpc + 32'd4;
          end
        end
        S_DRAIN: begin
          // The old request completes; its data is dropped and the latest target wins.
          if (w_ack) begin
            r_fpc   <= redirect_i ? w_redir_pc : r_tgt;
            r_state <= S_RUN;
          end else if (redirect_i) begin
            r_tgt <= w_redir_pc;
          end
        end
        default: r_state <= S_RUN;
      endcase
    end
  end

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (redirect_i),
    .i_data  (w_wdata),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign imem_req_o    = w_req;
  assign imem_addr_o   = r_fpc;
  assign instr_valid_o = !w_empty;
  assign instr_o       = w_head.instr;
  assign instr_pc_o    = w_head.pc;
  assign dbg_state_o   = r_state;
  assign dbg_count_o   = w_count;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed vector table, hand-written corner sequences
// and randomized traffic against a transaction-level fetch model.
module tb_instr_fetch;
  import instr_fetch_pkg::*;

  localparam int          DEPTH = 2;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic         clk;
  logic         rst_n;
  logic         redirect_i;
  logic [31:0]  redirect_pc_i;
  logic         imem_req_o;
  logic [31:0]  imem_addr_o;
  logic         imem_ack_i;
  logic [31:0]  imem_rdata_i;
  logic         instr_valid_o;
  logic [31:0]  instr_o;
  logic [31:0]  instr_pc_o;
  logic         instr_ready_i;
  fetch_state_t dbg_state_o;
  logic [1:0]   dbg_count_o;

  instr_fetch #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_ack_i    (imem_ack_i),
    .imem_rdata_i  (imem_rdata_i),
    .instr_valid_o (instr_valid_o),
    .instr_o       (instr_o),
    .instr_pc_o    (instr_pc_o),
    .instr_ready_i (instr_ready_i),
    .dbg_state_o   (dbg_state_o),
    .dbg_count_o   (dbg_count_o)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard / model state ----------------
  int          n_tests;
  int          n_fail;
  logic [63:0] exp_q[$];
  logic [31:0] m_fpc;
  logic [31:0] m_tgt;
  bit          m_drain;
  bit          m_pend;
  bit          m_started;
  int          wait_cnt;
  int          ack_delay;
  bit          rand_delay;
  bit          ack_hold;
  logic        p_req_hold;
  logic [31:0] p_addr;

  logic        s_req;
  logic        s_valid;
  logic [31:0] s_addr;
  logic [31:0] s_pc;
  logic [31:0] s_instr;

  typedef struct {
    logic        ready;
    logic        redir;
    logic [31:0] rpc;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
  } vec_t;
  vec_t vecs[6];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_0013;
  endfunction

  function automatic logic [31:0] align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

  task automatic chk1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst_n         = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = '0;
    imem_ack_i    = 1'b0;
    imem_rdata_i  = '0;
    instr_ready_i = 1'b0;
    #1;
    chk1 ("rst_req",   imem_req_o, 1'b0);
    chk32("rst_addr",  imem_addr_o, RPC);
    chk1 ("rst_valid", instr_valid_o, 1'b0);
    chk32("rst_instr", instr_o, 32'h0);
    chk32("rst_pc",    instr_pc_o, 32'h0);
    chk32("rst_count", 32'(dbg_count_o), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    m_fpc      = RPC;
    m_tgt      = '0;
    m_drain    = 1'b0;
    m_pend     = 1'b0;
    m_started  = 1'b0;
    wait_cnt   = 0;
    ack_delay  = 0;
    ack_hold   = 1'b0;
    p_req_hold = 1'b0;
    p_addr     = '0;
  endtask

  // One clock cycle: drive, let imem respond, compare with the model, advance.
  task automatic step(input logic redir, input logic [31:0] rpc, input logic rdy);
    logic exp_req;
    logic exp_valid;
    logic acc;
    logic pop;
    redirect_i    = redir;
    redirect_pc_i = rpc;
    instr_ready_i = rdy;
    imem_ack_i    = 1'b0;
    #1;
    imem_ack_i   = imem_req_o && !ack_hold && (wait_cnt >= ack_delay);
    imem_rdata_i = mem_word(imem_addr_o);
    #1;
    s_req   = imem_req_o;
    s_addr  = imem_addr_o;
    s_valid = instr_valid_o;
    s_pc    = instr_pc_o;
    s_instr = instr_o;

    exp_req   = m_started && (m_pend || (!m_drain && exp_q.size() < DEPTH && !redir));
    exp_valid = (exp_q.size() != 0);
    chk1("req", s_req, exp_req);
    if (exp_req) chk32("addr", s_addr, m_fpc);
    if (p_req_hold) begin
      chk1 ("hold_req",  s_req, 1'b1);
      chk32("hold_addr", s_addr, p_addr);
    end
    chk1("valid", s_valid, exp_valid);
    chk1("drain_state", dbg_state_o == S_DRAIN, m_drain);
    if (exp_valid) begin
      chk32("head_pc",    s_pc,    exp_q[0][63:32]);
      chk32("head_instr", s_instr, exp_q[0][31:0]);
    end

    acc = exp_req && imem_ack_i;
    pop = exp_valid && rdy && !redir;
    if (redir)    exp_q.delete();
    else if (pop) void'(exp_q.pop_front());
    if (!m_drain) begin
      if (redir) begin
        if (exp_req && !imem_ack_i) begin
          m_drain = 1'b1;
          m_tgt   = align(rpc);
        end else begin
          m_fpc = align(rpc);
        end
      end else if (acc) begin
        exp_q.push_back({m_fpc, mem_word(m_fpc)});
        m_fpc = m_fpc + 32'd4;
      end
    end else if (acc) begin
      m_fpc   = redir ? align(rpc) : m_tgt;
      m_drain = 1'b0;
    end else if (redir) begin
      m_tgt = align(rpc);
    end
    m_pend    = exp_req && !imem_ack_i;
    m_started = 1'b1;

    p_req_hold = s_req && !imem_ack_i;
    p_addr     = s_addr;
    if (s_req && !imem_ack_i) wait_cnt++;
    else if (imem_ack_i) begin
      wait_cnt = 0;
      if (rand_delay) ack_delay = $urandom_range(0, 3);
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    n_tests    = 0;
    n_fail     = 0;
    rand_delay = 1'b0;

    // Zero-wait imem, ready high: cycle 0 is the cycle right after release.
    vecs[0] = '{ready:1'b1, redir:1'b0, rpc:32'h0, exp_req:1'b0, exp_addr:32'h0,  exp_valid:1'b0, exp_pc:32'h0};
    vecs[1] = '{ready:1'b1, redir:1'b0, rpc:32'h0, exp_req:1'b1, exp_addr:32'h0,  exp_valid:1'b0, exp_pc:32'h0};
    vecs[2] = '{ready:1'b1, redir:1'b0, rpc:32'h0, exp_req:1'b1, exp_addr:32'h4,  exp_valid:1'b1, exp_pc:32'h0};
    vecs[3] = '{ready:1'b1, redir:1'b0, rpc:32'h0, exp_req:1'b1, exp_addr:32'h8,  exp_valid:1'b1, exp_pc:32'h4};
    vecs[4] = '{ready:1'b1, redir:1'b0, rpc:32'h0, exp_req:1'b1, exp_addr:32'hC,  exp_valid:1'b1, exp_pc:32'h8};
    vecs[5] = '{ready:1'b1, redir:1'b0, rpc:32'h0, exp_req:1'b1, exp_addr:32'h10, exp_valid:1'b1, exp_pc:32'hC};

    // 1. streaming after reset
    do_reset();
    foreach (vecs[i]) begin
      step(vecs[i].redir, vecs[i].rpc, vecs[i].ready);
      chk1("t1_req", s_req, vecs[i].exp_req);
      if (vecs[i].exp_req) chk32("t1_addr", s_addr, vecs[i].exp_addr);
      chk1("t1_valid", s_valid, vecs[i].exp_valid);
      if (vecs[i].exp_valid) chk32("t1_pc", s_pc, vecs[i].exp_pc);
    end

    // 2. backpressure fills the FIFO, then drains in order
    do_reset();
    repeat (5) step(1'b0, 32'h0, 1'b0);
    chk1 ("t2_req_off", s_req, 1'b0);
    chk32("t2_count",   32'(dbg_count_o), 32'd2);
    chk32("t2_head",    s_pc, 32'h0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 32'h0, 1'b1);
      chk1 ("t2_valid", s_valid, 1'b1);
      chk32("t2_order", s_pc, 32'(i * 4));
    end

    // 3. slow imem: request held stable until each ack
    do_reset();
    ack_delay = 3;
    repeat (24) step(1'b0, 32'h0, 1'b1);

    // 4. redirect while no request is outstanding
    do_reset();
    repeat (4) step(1'b0, 32'h0, 1'b0);
    step(1'b1, 32'h0000_0103, 1'b0);
    chk1("t4_idle", s_req, 1'b0);
    step(1'b0, 32'h0, 1'b0);
    chk1 ("t4_req",   s_req, 1'b1);
    chk32("t4_addr",  s_addr, 32'h100);
    chk1 ("t4_empty", s_valid, 1'b0);

    // 5. redirect during an un-acked fetch, then a second redirect in DRAIN
    do_reset();
    for (int k = 0; k < 10 && m_fpc != 32'h8; k++) step(1'b0, 32'h0, 1'b1);
    chk32("t5_reach", imem_addr_o, 32'h8);
    ack_hold = 1'b1;
    step(1'b0, 32'h0, 1'b1);
    step(1'b1, 32'h200, 1'b1);
    chk1 ("t5_keep_req",  s_req, 1'b1);
    chk32("t5_keep_addr", s_addr, 32'h8);
    step(1'b0, 32'h0, 1'b1);
    chk32("t5_drain_addr", s_addr, 32'h8);
    chk1 ("t5_flushed",    s_valid, 1'b0);
    step(1'b1, 32'h300, 1'b1);
    ack_hold = 1'b0;
    step(1'b0, 32'h0, 1'b1);
    chk32("t5_ack_old", s_addr, 32'h8);
    step(1'b0, 32'h0, 1'b1);
    chk1 ("t5_new_req",  s_req, 1'b1);
    chk32("t5_new_addr", s_addr, 32'h300);
    chk1 ("t5_discard",  s_valid, 1'b0);
    step(1'b0, 32'h0, 1'b1);
    chk32("t5_first_pc", s_pc, 32'h300);

    // 6. reset mid-DRAIN, reset with a full FIFO, then resume
    ack_hold = 1'b1;
    step(1'b0, 32'h0, 1'b1);
    step(1'b1, 32'h400, 1'b1);
    chk1("t6_in_drain", dbg_state_o == S_DRAIN, 1'b1);
    do_reset();
    repeat (4) step(1'b0, 32'h0, 1'b0);
    chk32("t6_full", 32'(dbg_count_o), 32'd2);
    do_reset();
    step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    chk1 ("t6_resume_req",  s_req, 1'b1);
    chk32("t6_resume_addr", s_addr, RPC);

    // 7. randomized traffic, including targets near the top of memory
    do_reset();
    rand_delay = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      logic        r;
      logic [31:0] t;
      if (i == 700) do_reset();
      r = ($urandom_range(0, 9) == 0);
      t = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15))) : $urandom;
      step(r, t, ($urandom_range(0, 3) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
